// File: rtl/axa_undo_ctrl_pkg.sv
// Shared types and sizing for the AXA undo stack controller.
// No logic; constants and the sequencer state encoding only.
// Imported by the arbiter and the stack top.
package axa_undo_ctrl_pkg;

  localparam int UC_WIDTH = 16;
  localparam int UC_PTRW  = 4;

  // Direction sequencer states; TURN is the single bubble between directions.
  typedef enum logic [1:0] {
    UC_FWD  = 2'd0,
    UC_TURN = 2'd1,
    UC_REV  = 2'd2
  } uc_state_e;

endpackage

// File: rtl/axa_undo_arb.sv
// Direction FSM and grant logic for the undo stack requesters.
// Grants are combinational, same cycle as request; state moves on clk.
// Losing or refused requesters see gnt=0 and are expected to hold.
module axa_undo_arb
  import axa_undo_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic fwd,
  input  logic clear,
  input  logic push_req,
  input  logic alu_req,
  input  logic land_req,
  output logic push_gnt,
  output logic alu_gnt,
  output logic land_gnt
);

  uc_state_e state, state_nxt;

  // State register; synchronous reset back to forward execution.
  always_ff @(posedge clk) begin
    if (reset) state <= UC_FWD;
    else       state <= state_nxt;
  end

  // Next state and grants; clear and reset suppress every grant.
  always_comb begin
    state_nxt = state;
    push_gnt  = 1'b0;
    alu_gnt   = 1'b0;
    land_gnt  = 1'b0;
    unique case (state)
      UC_FWD: begin
        push_gnt = push_req && !clear && !reset;
        if (!fwd) state_nxt = UC_TURN;
      end
      UC_TURN: begin
        state_nxt = fwd ? UC_FWD : UC_REV;
      end
      UC_REV: begin
        // Land pop outranks the ALU restore pop.
        land_gnt = land_req && !clear && !reset;
        alu_gnt  = alu_req && !land_req && !clear && !reset;
        if (fwd) state_nxt = UC_TURN;
      end
      default: state_nxt = UC_FWD;
    endcase
  end

endmodule

// File: rtl/axa_undo_ctrl.sv
// AXA undo stack: circular buffer of saved values, push forward / pop reverse.
// Push and pop take effect at the grant edge; pop_data/pop_valid one cycle later.
// Requests are never stalled by flow control beyond the comb gnt from the arbiter.
module axa_undo_ctrl
  import axa_undo_ctrl_pkg::*;
#(
  parameter int WIDTH = UC_WIDTH,
  parameter int PTRW  = UC_PTRW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fwd,
  input  logic             push_req,
  input  logic [WIDTH-1:0] push_data,
  output logic             push_gnt,
  input  logic             alu_req,
  input  logic             land_req,
  output logic             alu_gnt,
  output logic             land_gnt,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid,
  input  logic [PTRW-1:0]  peek_off,
  output logic [WIDTH-1:0] peek_data,
  input  logic             clear,
  output logic [PTRW-1:0]  sp,
  output logic [PTRW:0]    count,
  output logic             ovf,
  output logic             unf
);

  localparam logic [PTRW:0]   FULL    = {1'b1, {PTRW{1'b0}}};
  localparam logic [PTRW-1:0] PTR_ONE = {{(PTRW-1){1'b0}}, 1'b1};
  localparam logic [PTRW:0]   CNT_ONE = {{PTRW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [2**PTRW];
  logic             pop_gnt;
  logic [PTRW-1:0]  top_idx;
  logic [PTRW-1:0]  peek_idx;

  axa_undo_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .fwd      (fwd),
    .clear    (clear),
    .push_req (push_req),
    .alu_req  (alu_req),
    .land_req (land_req),
    .push_gnt (push_gnt),
    .alu_gnt  (alu_gnt),
    .land_gnt (land_gnt)
  );

  assign pop_gnt   = alu_gnt | land_gnt;
  assign top_idx   = sp - PTR_ONE;
  assign peek_idx  = sp - peek_off - PTR_ONE;
  assign peek_data = mem[peek_idx];

  // Storage write; contents survive reset and clear on purpose.
  always_ff @(posedge clk) begin
    if (push_gnt) mem[sp] <= push_data;
  end

  // Pointer, occupancy, popped value and sticky error flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp        <= '0;
      count     <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
      ovf       <= 1'b0;
      unf       <= 1'b0;
    end else begin
      pop_valid <= pop_gnt;
      if (clear) begin
        count <= '0;
      end else if (push_gnt) begin
        sp <= sp + PTR_ONE;
        // At full occupancy the push lands on the oldest entry.
        if (count == FULL) ovf   <= 1'b1;
        else               count <= count + CNT_ONE;
      end else if (pop_gnt) begin
        if (count != '0) begin
          pop_data <= mem[top_idx];
          sp       <= top_idx;
          count    <= count - CNT_ONE;
        end else begin
          // Empty pop still completes so the requester is not stalled.
          pop_data <= '0;
          unf      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axa_undo_ctrl.sv
// Self-checking bench for axa_undo_ctrl: queue-style reference model plus
// directed scenarios with hand-computed literal expectations.
module tb_axa_undo_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fwd;
  logic        push_req;
  logic [15:0] push_data;
  logic        push_gnt;
  logic        alu_req;
  logic        land_req;
  logic        alu_gnt;
  logic        land_gnt;
  logic [15:0] pop_data;
  logic        pop_valid;
  logic [3:0]  peek_off;
  logic [15:0] peek_data;
  logic        clear;
  logic [3:0]  sp;
  logic [4:0]  count;
  logic        ovf;
  logic        unf;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axa_undo_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .fwd       (fwd),
    .push_req  (push_req),
    .push_data (push_data),
    .push_gnt  (push_gnt),
    .alu_req   (alu_req),
    .land_req  (land_req),
    .alu_gnt   (alu_gnt),
    .land_gnt  (land_gnt),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .peek_off  (peek_off),
    .peek_data (peek_data),
    .clear     (clear),
    .sp        (sp),
    .count     (count),
    .ovf       (ovf),
    .unf       (unf)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // mode: 0 forward, 1 turnaround bubble, 2 reverse
  int   m_mode;
  int   m_mem [16];
  int   m_sp, m_cnt, m_pd;
  bit   m_pv, m_ovf, m_unf;
  bit   m_ok = 0;

  function automatic bit e_push();
    return !reset && !clear && m_mode == 0 && push_req;
  endfunction
  function automatic bit e_land();
    return !reset && !clear && m_mode == 2 && land_req;
  endfunction
  function automatic bit e_alu();
    return !reset && !clear && m_mode == 2 && alu_req && !land_req;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_mode = 0; m_sp = 0; m_cnt = 0; m_pd = 0;
      m_pv = 0; m_ovf = 0; m_unf = 0; m_ok = 1;
    end else if (m_ok) begin
      bit gp, gl, ga;
      gp = e_push(); gl = e_land(); ga = e_alu();
      m_pv = gl || ga;
      if (clear) m_cnt = 0;
      else if (gp) begin
        m_mem[m_sp] = int'(push_data);
        m_sp = (m_sp + 1) % 16;
        if (m_cnt == 16) m_ovf = 1;
        else m_cnt++;
      end else if (gl || ga) begin
        if (m_cnt > 0) begin
          m_sp = (m_sp + 15) % 16;
          m_pd = m_mem[m_sp];
          m_cnt--;
        end else begin
          m_pd = 0;
          m_unf = 1;
        end
      end
      case (m_mode)
        0: if (!fwd) m_mode = 1;
        1: m_mode = fwd ? 0 : 2;
        default: if (fwd) m_mode = 1;
      endcase
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("push_gnt", push_gnt, e_push());
      chk("land_gnt", land_gnt, e_land());
      chk("alu_gnt", alu_gnt, e_alu());
      chk("pop_valid", pop_valid, m_pv);
      if (m_pv) chk("pop_data", pop_data, m_pd);
      chk("sp", sp, m_sp);
      chk("count", count, m_cnt);
      chk("ovf", ovf, m_ovf);
      chk("unf", unf, m_unf);
      if (int'(peek_off) < m_cnt)
        chk("peek_data", peek_data, m_mem[(m_sp - int'(peek_off) - 1 + 32) % 16]);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic peekchk(input string nm, input logic [3:0] off, input logic [15:0] exp);
    peek_off = off; #1;
    chk(nm, peek_data, exp);
  endtask

  logic [15:0] t1_vals [3] = '{16'h1111, 16'h2222, 16'h3333};
  logic [15:0] t2_vals [3] = '{16'h3333, 16'h2222, 16'h1111};

  initial begin
    reset = 1; fwd = 1; push_req = 0; push_data = 0; alu_req = 0;
    land_req = 0; peek_off = 0; clear = 0;
    tick(); tick();
    reset = 0; #1;
    chk("rst_sp", sp, 0);
    chk("rst_count", count, 0);
    chk("rst_pop_valid", pop_valid, 0);
    chk("rst_pop_data", pop_data, 0);
    chk("rst_flags", {ovf, unf}, 0);

    // 1) three forward pushes
    for (int i = 0; i < 3; i++) begin
      push_req = 1; push_data = t1_vals[i]; #1;
      chk("t1_push_gnt", push_gnt, 1);
      tick();
    end
    push_req = 0; #1;
    chk("t1_sp", sp, 3);
    chk("t1_count", count, 3);
    peekchk("t1_peek0", 4'd0, 16'h3333);
    peekchk("t1_peek2", 4'd2, 16'h1111);
    peek_off = 0;

    // 2) turn around and restore-pop everything
    fwd = 0; alu_req = 1; #1;
    chk("t2_fwd_nogrant", alu_gnt, 0);
    tick(); #1;
    chk("t2_turn_nogrant", alu_gnt, 0);
    tick(); #1;
    chk("t2_rev_grant", alu_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("t2_pop_valid", pop_valid, 1);
      chk("t2_pop_data", pop_data, t2_vals[i]);
    end
    // 3) pop on empty stack
    chk("t3_alu_gnt", alu_gnt, 1);
    tick(); #1;
    chk("t3_pop_valid", pop_valid, 1);
    chk("t3_pop_data", pop_data, 0);
    chk("t3_unf", unf, 1);
    chk("t3_sp", sp, 0);
    alu_req = 0;
    tick(); #1;
    chk("t3_valid_pulse", pop_valid, 0);

    // 4) land beats alu
    fwd = 1; tick(); tick();
    push_req = 1; push_data = 16'h0055; tick();
    push_data = 16'h00A0; tick();
    push_req = 0; fwd = 0; tick(); tick();
    land_req = 1; alu_req = 1; #1;
    chk("t4_land_gnt", land_gnt, 1);
    chk("t4_alu_lose", alu_gnt, 0);
    tick(); land_req = 0; #1;
    chk("t4_land_data", pop_data, 16'h00A0);
    chk("t4_alu_gnt", alu_gnt, 1);
    tick(); alu_req = 0; #1;
    chk("t4_alu_data", pop_data, 16'h0055);
    chk("t4_alu_valid", pop_valid, 1);

    // 5) overflow with 17 pushes
    reset = 1; fwd = 1; tick(); reset = 0;
    for (int v = 1; v <= 17; v++) begin
      push_req = 1; push_data = 16'(v); tick();
    end
    push_req = 0; #1;
    chk("t5_count", count, 16);
    chk("t5_ovf", ovf, 1);
    chk("t5_sp", sp, 1);
    peekchk("t5_peek0", 4'd0, 16'd17);
    peekchk("t5_peek15", 4'd15, 16'd2);
    peek_off = 0;

    // 6) clear beats push, then reset during a reverse pop
    reset = 1; tick(); reset = 0;
    for (int v = 0; v < 3; v++) begin
      push_req = 1; push_data = 16'(16'h0100 + v); tick();
    end
    clear = 1; #1;
    chk("t6_clear_gnt", push_gnt, 0);
    tick(); clear = 0; push_req = 0; #1;
    chk("t6_count", count, 0);
    chk("t6_sp", sp, 3);
    push_req = 1; push_data = 16'h0BEE; tick(); push_req = 0;
    fwd = 0; tick(); tick();
    alu_req = 1; #1;
    chk("t6_rev_gnt", alu_gnt, 1);
    reset = 1; #1;
    chk("t6_rst_gnt", alu_gnt, 0);
    tick(); reset = 0; alu_req = 0; #1;
    chk("t6_rst_valid", pop_valid, 0);
    chk("t6_rst_sp", sp, 0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
